// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised inter-stage pipeline buffer.
// Carries one opaque payload through DEPTH entries with the core's
// valid/allowin handshake, per-stage ready_go gating, synchronous flush
// and an occupancy count.
//
// Ports:
//   clk, rst     sole clock; synchronous active-high reset
//   up_valid     upstream offers up_data
//   up_data      upstream payload (DATA_W bits)
//   up_allowin   buffer accepts up_data this cycle
//   ready_go     head entry may leave this cycle (stage hazard gate)
//   dn_allowin   downstream accepts this cycle
//   dn_valid     head entry present and ready_go asserted
//   dn_data      head entry payload
//   head_valid   head entry present, regardless of ready_go
//   flush        discard all held entries
//   count        number of held entries, 0..DEPTH
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              up_allowin,
    input  logic              ready_go,
    input  logic              dn_allowin,
    output logic              dn_valid,
    output logic [DATA_W-1:0] dn_data,
    output logic              head_valid,
    input  logic              flush,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              full;
    logic              empty;
    logic              dn_fire;
    logic              up_fire;

    // Explicit wrap so non-power-of-2 depths index only 0..DEPTH-1;
    // with DEPTH = 1 the pointer is pinned at 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        full       = (cnt_q == CNT_W'(DEPTH));
        empty      = (cnt_q == '0);
        head_valid = ~empty;
        dn_valid   = ~empty & ready_go;
        dn_fire    = dn_valid & dn_allowin;
        // A departing head frees its slot in the same cycle, which keeps
        // full throughput even at DEPTH = 1.
        up_allowin = ~full | dn_fire;
        up_fire    = up_valid & up_allowin & ~flush;
        dn_data    = mem[rd_ptr];
        count      = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // A head sampled by downstream this cycle is already delivered;
            // dropping it with the rest is correct. mem is left as is.
            cnt_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (up_fire) begin
                mem[wr_ptr] <= up_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (dn_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({up_fire, dn_fire})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline stage buffer for the core's inter-stage boundaries (IF/ID, ID/EX, EX/MEM, …). It carries one opaque payload bus with the same valid/allowin handshake and per-stage ready_go gating the core already uses. It generalises the single-entry stage register to DEPTH entries, and adds a synchronous flush and an occupancy count. Stages instantiate it with the concatenated control/data fields as the payload.

## Interface
- DATA_W, 64: payload width in bits (≥1).
- DEPTH, 1: number of entries (≥1; non-power-of-2 allowed).
- CNT_W, $clog2(DEPTH+1): width of the occupancy count (derived, not overridden).
- clk  in  1  sole clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- up_valid  in  1  upstream has a payload on up_data.
- up_data  in  DATA_W  upstream payload.
- up_allowin  out  1  buffer accepts up_data this cycle.
- ready_go  in  1  head entry may leave this cycle (stage-local hazard gate, e.g. load-use stall = 0).
- dn_allowin  in  1  downstream accepts this cycle.
- dn_valid  out  1  head entry is present and ready_go = 1.
- dn_data  out  DATA_W  head entry payload.
- head_valid  out  1  head entry is present, independent of ready_go (for hazard/forwarding logic).
- flush  in  1  discard all held entries (redirect/exception).
- count  out  CNT_W  number of held entries, 0..DEPTH.

## Operation
- Definitions:
  - full = (count == DEPTH); empty = (count == 0).
  - dn_fire = dn_valid & dn_allowin.
  - up_fire = up_valid & up_allowin & ~flush.
- head_valid = ~empty; dn_valid = ~empty & ready_go.
- up_allowin = ~full | dn_fire. This is a combinational path from dn_allowin and ready_go, matching the existing stage chain.
- Storage is a circular buffer mem[0..DEPTH-1] with rd_ptr and wr_ptr.
  - Each pointer advances by 1 and wraps to 0 after DEPTH-1; the wrap is explicit, not a power-of-2 truncation.
  - DEPTH = 1 degenerates to a single register with both pointers held at 0.
- dn_data = mem[rd_ptr]. When head_valid = 0 its value is don't-care, except that it is 0 after reset.
- Per cycle, when flush = 0:
  - up_fire writes mem[wr_ptr] and advances wr_ptr.
  - dn_fire advances rd_ptr.
  - count += up_fire − dn_fire. Simultaneous fire leaves count unchanged, including when full.
- Per cycle, when flush = 1:
  - Next-cycle count = 0 and rd_ptr = wr_ptr = 0.
  - up_valid is ignored and no write occurs.
  - A dn_fire in the same cycle is still a completed transfer, because downstream sampled it; the entry is not re-presented.
  - mem contents are not cleared.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush.
- Payload is never modified or inspected.

## Timing
- Reset (rst = 1 at posedge): count = 0, rd_ptr = wr_ptr = 0, all mem entries = 0.
  - Resulting outputs: dn_valid = 0, head_valid = 0, dn_data = 0, up_allowin = 1.
- rst has priority over flush. rst asserted mid-transfer discards everything, exactly as at power-up.
- Latency: a payload accepted at edge N is on dn_data with head_valid = 1 from N+1. dn_valid follows at N+1 if ready_go = 1. There is no same-cycle bypass.
- Throughput: one transfer per cycle in steady state for any DEPTH, including DEPTH = 1 via the dn_fire term in up_allowin.
- Stall hold:
  - ready_go = 0 or dn_allowin = 0 holds the head entry and dn_data stable.
  - While the stall lasts, up_allowin stays 1 until count reaches DEPTH.
- Flush: takes effect at the next edge. dn_valid = 0 in the cycle after flush, and up_allowin = 1 in that cycle.
- No outputs are registered apart from state; dn_valid, dn_data and up_allowin are combinational from state plus ready_go/dn_allowin.

## Test plan
- Reset → count = 0, dn_valid = 0, head_valid = 0, dn_data = 0, up_allowin = 1. Repeat with rst asserted while count = DEPTH → same values next cycle.
- Streaming, DEPTH = 1, DATA_W = 64: up_valid = 1 with data 1, 2, 3 …, dn_allowin = ready_go = 1 → dn_data 1, 2, 3 … one per cycle, each 1 cycle after acceptance, with up_allowin never dropping.
- Fill/drain, DEPTH = 3: push A, B, C with dn_allowin = 0 → count = 3, up_allowin = 0, D not accepted. Then dn_allowin = 1 and push D → A, B, C, D delivered in order, pointers wrap, count stays 3 while pushing and draining together.
- ready_go gating, DEPTH = 2 holding X: ready_go = 0 for 4 cycles → head_valid = 1, dn_valid = 0, dn_data = X held, count unchanged. ready_go = 1 → X delivered.
- Flush, DEPTH = 4, count = 3, with up_valid = 1 (Y) and dn_fire of head in the same cycle → next cycle count = 0, dn_valid = 0, Y never appears, head counted as delivered exactly once.
- Full simultaneous fire, DEPTH = 2 full, dn_fire = 1 and up_valid = 1 → up_allowin = 1, count stays 2, new entry emerges after the remaining one.
